// File: rtl/div_iter_unit.sv
// Iterative restoring 32-bit divider (DIV/DIVU) for the execute stage.
// Produces the E-stage stall request and the {HI=remainder, LO=quotient} result.
module div_iter_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        stall_div,
  output logic        ready,
  output logic [63:0] result
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on accept
  // RUN   | one restoring step per cycle, 32 cycles
  // DONE  | result presented with ready; returns to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] rq;
  logic [31:0] mag_b;
  logic [31:0] a_cap;
  logic [4:0]  cnt;
  logic        sign_q, sign_r, dz;
  logic [63:0] result_q;

  logic        accept;
  logic        load;
  logic [31:0] mag_a_in, mag_b_in;
  logic [32:0] diff;
  logic [63:0] step;
  logic [31:0] quo_fin, rem_fin;
  logic [63:0] fin;

  assign accept   = start & ~annul;
  assign mag_a_in = (signed_div & a[31]) ? (~a + 32'd1) : a;
  assign mag_b_in = (signed_div & b[31]) ? (~b + 32'd1) : b;

  // 33-bit compare: the bit shifted out of rem can make it exceed 32 bits
  assign diff = rq[63:31] - {1'b0, mag_b};

  always_comb begin
    step = {rq[62:0], 1'b0};
    if (!diff[32]) step = {diff[31:0], rq[30:0], 1'b1};
  end

  assign quo_fin = sign_q ? (~rq[31:0] + 32'd1) : rq[31:0];
  assign rem_fin = sign_r ? (~rq[63:32] + 32'd1) : rq[63:32];
  assign fin     = dz ? {a_cap, 32'hFFFF_FFFF} : {rem_fin, quo_fin};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (b == 32'd0) ? DONE : RUN;
      RUN: begin
        if (annul)               state_nxt = IDLE;
        else if (cnt == 5'd31)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq     <= '0;
      mag_b  <= '0;
      a_cap  <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz     <= 1'b0;
    end else if (state == IDLE && accept) begin
      rq     <= {32'd0, mag_a_in};
      mag_b  <= mag_b_in;
      a_cap  <= a;
      cnt    <= '0;
      sign_q <= signed_div & (a[31] ^ b[31]);
      sign_r <= signed_div & a[31];
      dz     <= (b == 32'd0);
    end else if (state == RUN && !annul) begin
      rq  <= step;
      cnt <= cnt + 5'd1;
    end
  end

  assign load = (state == DONE) & ~annul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      result_q <= '0;
    else if (load) result_q <= fin;
  end

  // The final value is already stable in DONE, so it is forwarded in that
  // cycle alongside ready; the register holds it for later cycles.
  assign result    = load ? fin : result_q;
  assign ready     = rst & load;
  assign stall_div = rst & ~annul & (((state == IDLE) & start) | (state == RUN));

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Iterative 32-bit divider for the execute stage, serving MIPS DIV/DIVU. It produces the stall request that the pipeline controller consumes as its execute-stage stall input, and the {HI,LO} result written through the HI/LO write path. The execute stage issues a request and holds it. The unit asserts stall for the full computation and releases it in the cycle the result is valid.

## Interface
Parameters:
- none (datapath fixed at 32 bits)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  divide request from E stage; held high while the instruction sits in E
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE
- a  in  32  dividend; sampled with start in IDLE
- b  in  32  divisor; sampled with start in IDLE
- annul  in  1  cancel request (E-stage flush); overrides start
- stall_div  out  1  stall request to the pipeline (combinational)
- ready  out  1  one-cycle pulse: result valid this cycle
- result  out  64  {HI = remainder, LO = quotient}; registered

## Operation
- States: IDLE, RUN, DONE. Encoding is free. Reset state is IDLE.
- IDLE:
  - If start & ~annul: capture sign_q = signed_div & (a[31]^b[31]) and sign_r = signed_div & a[31].
  - Capture the magnitudes |a| and |b|. Magnitudes are 32-bit unsigned; negation of 0x80000000 is 0x80000000.
  - Clear the 64-bit partial remainder/quotient register and the 5-bit counter.
  - If b == 0, go to DONE with div-by-zero flag set. Otherwise go to RUN.
- RUN: one restoring step per cycle.
  - Shift {rem,quo} left by 1.
  - If rem ≥ |b|, then rem -= |b| and set quo[0] = 1.
  - Counter increments each cycle. After the step with counter == 31, go to DONE.
- DONE:
  - Load result and pulse ready. Go to IDLE unconditionally; start is ignored in DONE.
  - Normal case: LO = sign_q ? -quo : quo; HI = sign_r ? -rem : rem.
  - Div-by-zero case: LO = 0xFFFFFFFF, HI = a as captured (unsigned, regardless of signed_div).
- start is ignored in RUN and DONE; inputs a, b and signed_div are not re-sampled.
- annul in RUN or DONE:
  - Next state is IDLE. ready is not pulsed and result is not updated.
  - annul in DONE suppresses the result load.
- result holds its last value until the next completed operation.

## Timing
- stall_div = ~annul & ((state==IDLE & start) | state==RUN). It is deasserted in the DONE cycle, so the instruction advances on the same edge the result is usable.
- Normal latency: start seen in IDLE at cycle 0, RUN in cycles 1..32, DONE and ready in cycle 33, back in IDLE at cycle 34. stall_div is high in cycles 0..32.
- Div-by-zero: stall_div high in cycle 0 only, ready in cycle 1.
- Back-to-back: a new start can be accepted in the cycle after DONE.
- Reset values: state IDLE, result 0, ready 0, counter 0, internal registers 0. stall_div is 0 while in reset regardless of start.
- Asserting rst mid-RUN returns the unit to IDLE immediately (asynchronous). No ready pulse occurs and result is 0.

## Test plan
- Unsigned 100 / 7 (signed_div=0), start held: stall_div high cycles 0..32; ready at cycle 33 with result = {HI=2, LO=14}.
- Signed −7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Signed 7 / −2: LO = 0xFFFFFFFD, HI = 1.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Unsigned 0xFFFFFFFF / 1: LO = 0xFFFFFFFF, HI = 0.
- Divide by zero, a = 0x1234, b = 0: ready at cycle 1, LO = 0xFFFFFFFF, HI = 0x1234, stall_div high only in cycle 0.
- annul asserted at cycle 10 of a run: stall_div low that cycle, IDLE next cycle, no ready pulse, result keeps its previous value. A fresh 9/3 request then completes with LO = 3, HI = 0.
- Two back-to-back divides with start held through DONE: exactly one ready pulse per instruction, and no re-trigger in the DONE cycle. rst pulled low at cycle 5 of a run: outputs return to their reset values immediately.
